// File: rtl/regfile_sb.sv
// Integer register file (x0..x31, 64-bit) with a per-register pending-write scoreboard.
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic        rs1_rena,
    input  logic        rs2_rena,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data,
    input  logic        issue_valid,
    input  logic        issue_rd_wena,
    input  logic [4:0]  issue_rd_addr,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd_addr,
    input  logic [63:0] wb_rd_data,
    output logic        stall,
    output logic [31:0] busy_vec
);

    logic [63:0] regs_q [32];
    logic [63:0] regs_d [32];
    logic [31:0] pending_q;
    logic [31:0] pending_d;

    logic        rs1_raw;
    logic        rs2_raw;
    logic        waw;
    logic        wb_clears_rd;
    logic        issue_wr;

`ifdef REGFILE_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = wb_valid && (wb_rd_addr == rs1_addr) && (rs1_addr != 5'd0);
    assign rs2_hit = wb_valid && (wb_rd_addr == rs2_addr) && (rs2_addr != 5'd0);
`endif

    // Operand read: disabled or x0 sources read zero.
    always_comb begin
        rs1_data = 64'd0;
        rs2_data = 64'd0;
        if (rs1_rena && (rs1_addr != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
            rs1_data = rs1_hit ? wb_rd_data : regs_q[rs1_addr];
`else
            rs1_data = regs_q[rs1_addr];
`endif
        end
        if (rs2_rena && (rs2_addr != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
            rs2_data = rs2_hit ? wb_rd_data : regs_q[rs2_addr];
`else
            rs2_data = regs_q[rs2_addr];
`endif
        end
    end

    // Issue handshake: decode presents an instruction with issue_valid=1; it is
    // accepted on the rising edge only when stall=0, otherwise decode holds it.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rs1_raw = rs1_rena && (rs1_addr != 5'd0) && pending_q[rs1_addr] && !rs1_hit;
        rs2_raw = rs2_rena && (rs2_addr != 5'd0) && pending_q[rs2_addr] && !rs2_hit;
`else
        rs1_raw = rs1_rena && (rs1_addr != 5'd0) && pending_q[rs1_addr];
        rs2_raw = rs2_rena && (rs2_addr != 5'd0) && pending_q[rs2_addr];
`endif
        wb_clears_rd = wb_valid && (wb_rd_addr == issue_rd_addr);
        waw          = issue_rd_wena && (issue_rd_addr != 5'd0) &&
                       pending_q[issue_rd_addr] && !wb_clears_rd;
        stall        = issue_valid && (rs1_raw || rs2_raw || waw);
        issue_wr     = issue_valid && issue_rd_wena && (issue_rd_addr != 5'd0) && !stall;
    end

    // Writeback clears the pending bit first so a same-edge issue re-sets it.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_valid && (wb_rd_addr != 5'd0)) begin
            regs_d[wb_rd_addr]    = wb_rd_data;
            pending_d[wb_rd_addr] = 1'b0;
        end
        if (issue_wr) begin
            pending_d[issue_rd_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 64'd0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Bit 0 of pending_q is never set, so it maps directly onto busy_vec.
    assign busy_vec = pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against a queue-based scoreboard model.
// Expectations follow the build: REGFILE_BYPASS_EN selects forwarding behaviour.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_rena;
    logic        rs2_rena;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        issue_valid;
    logic        issue_rd_wena;
    logic [4:0]  issue_rd_addr;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_rd_data;
    logic        stall;
    logic [31:0] busy_vec;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference state: register contents and a list of outstanding destinations.
    logic [63:0] mregs [32];
    int          pend_q[$];

    regfile_sb dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_rena      (rs1_rena),
        .rs2_rena      (rs2_rena),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .issue_valid   (issue_valid),
        .issue_rd_wena (issue_rd_wena),
        .issue_rd_addr (issue_rd_addr),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_data    (wb_rd_data),
        .stall         (stall),
        .busy_vec      (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic bit is_pending(logic [4:0] a);
        foreach (pend_q[i]) begin
            if (pend_q[i] == int'(a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit wb_fwd(logic [4:0] a);
        return BYPASS && wb_valid && (wb_rd_addr == a) && (a != 5'd0);
    endfunction

    function automatic logic [63:0] exp_read(logic [4:0] a, logic en);
        if (!en || a == 5'd0) return 64'd0;
        if (wb_fwd(a)) return wb_rd_data;
        return mregs[a];
    endfunction

    function automatic bit src_hazard(logic [4:0] a, logic en);
        return en && (a != 5'd0) && is_pending(a) && !wb_fwd(a);
    endfunction

    function automatic logic exp_stall();
        bit waw_h;
        if (!issue_valid) return 1'b0;
        waw_h = issue_rd_wena && (issue_rd_addr != 5'd0) && is_pending(issue_rd_addr) &&
                !(wb_valid && wb_rd_addr == issue_rd_addr);
        return src_hazard(rs1_addr, rs1_rena) || src_hazard(rs2_addr, rs2_rena) || waw_h;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v = 32'd0;
        foreach (pend_q[i]) v[pend_q[i]] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;
        rs1_rena      = 1'b0;
        rs2_rena      = 1'b0;
        issue_valid   = 1'b0;
        issue_rd_wena = 1'b0;
        issue_rd_addr = 5'd0;
        wb_valid      = 1'b0;
        wb_rd_addr    = 5'd0;
        wb_rd_data    = 64'd0;
    endtask

    task automatic issue(logic [4:0] rd);
        issue_valid   = 1'b1;
        issue_rd_wena = 1'b1;
        issue_rd_addr = rd;
    endtask

    task automatic wb(logic [4:0] rd, logic [63:0] d);
        wb_valid   = 1'b1;
        wb_rd_addr = rd;
        wb_rd_data = d;
    endtask

    // Combinational outputs, sampled mid-cycle after inputs settle.
    task automatic check_comb();
        #1;
        chk("stall", {63'd0, stall}, {63'd0, exp_stall()});
        chk("rs1_data", rs1_data, exp_read(rs1_addr, rs1_rena));
        chk("rs2_data", rs2_data, exp_read(rs2_addr, rs2_rena));
    endtask

    // Advance one edge, apply the architectural rules to the model, check busy_vec.
    task automatic clock();
        bit accepted;
        accepted = issue_valid && issue_rd_wena && (issue_rd_addr != 5'd0) && !exp_stall();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
            pend_q.delete();
        end else begin
            if (wb_valid && wb_rd_addr != 5'd0) begin
                mregs[wb_rd_addr] = wb_rd_data;
                for (int i = pend_q.size() - 1; i >= 0; i--) begin
                    if (pend_q[i] == int'(wb_rd_addr)) pend_q.delete(i);
                end
            end
            if (accepted) pend_q.push_back(int'(issue_rd_addr));
        end
        chk("busy_vec", {32'd0, busy_vec}, {32'd0, exp_busy()});
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;

        idle(); rst = 1'b1; clock();
        idle(); check_comb(); clock();

        // Basic write/read and x0 behaviour
        wb(5'd5, 64'h1234); check_comb(); clock();
        idle(); rs1_rena = 1'b1; rs1_addr = 5'd5; check_comb();
        chk("x5_read", rs1_data, 64'h1234); clock();
        idle(); wb(5'd0, 64'hFFFF); check_comb(); clock();
        idle(); rs1_rena = 1'b1; rs1_addr = 5'd0; check_comb();
        chk("x0_read", rs1_data, 64'h0); clock();

        // RAW on x7, resolved by writeback
        idle(); issue(5'd7); check_comb(); clock();
        idle(); issue_valid = 1'b1; rs2_rena = 1'b1; rs2_addr = 5'd7; check_comb();
        chk("x7_raw_stall", {63'd0, stall}, 64'd1);
        chk("x7_busy", {63'd0, busy_vec[7]}, 64'd1); clock();
        wb(5'd7, 64'hAA); check_comb();
        chk("x7_wb_stall", {63'd0, stall}, BYPASS ? 64'd0 : 64'd1);
        chk("x7_wb_data", rs2_data, BYPASS ? 64'hAA : 64'h0); clock();
        wb_valid = 1'b0; check_comb();
        chk("x7_after_stall", {63'd0, stall}, 64'd0);
        chk("x7_after_data", rs2_data, 64'hAA); clock();

        // Same-edge writeback and reissue of x9: set wins
        idle(); issue(5'd9); check_comb(); clock();
        issue(5'd9); wb(5'd9, 64'h99); check_comb();
        chk("x9_same_edge_stall", {63'd0, stall}, 64'd0); clock();
        chk("x9_busy_kept", {63'd0, busy_vec[9]}, 64'd1);
        idle(); wb(5'd9, 64'h999); check_comb(); clock();

        // WAW on x3
        idle(); issue(5'd3); check_comb(); clock();
        issue(5'd3); check_comb();
        chk("x3_waw_stall", {63'd0, stall}, 64'd1); clock();
        chk("x3_busy_held", {63'd0, busy_vec[3]}, 64'd1);
        idle(); wb(5'd3, 64'h33); check_comb(); clock();
        chk("x3_busy_clear", {63'd0, busy_vec[3]}, 64'd0);
        idle(); issue(5'd3); check_comb();
        chk("x3_reissue_stall", {63'd0, stall}, 64'd0); clock();
        chk("x3_reissue_busy", {63'd0, busy_vec[3]}, 64'd1);
        idle(); wb(5'd3, 64'h333); check_comb(); clock();

        // Reset mid-operation with x4/x6 written and pending
        idle(); wb(5'd4, 64'h44); check_comb(); clock();
        wb(5'd6, 64'h66); check_comb(); clock();
        idle(); issue(5'd4); check_comb(); clock();
        issue(5'd6); check_comb(); clock();
        idle(); rst = 1'b1; issue(5'd2); wb(5'd4, 64'h4444); check_comb(); clock();
        chk("rst_busy", {32'd0, busy_vec}, 64'd0);
        idle(); issue_valid = 1'b1; rs1_rena = 1'b1; rs1_addr = 5'd4;
        rs2_rena = 1'b1; rs2_addr = 5'd6; check_comb();
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_x4", rs1_data, 64'd0);
        chk("rst_x6", rs2_data, 64'd0); clock();

        // Both ports on pending x8, then read enables dropped
        idle(); issue(5'd8); check_comb(); clock();
        idle(); issue_valid = 1'b1; rs1_rena = 1'b1; rs2_rena = 1'b1;
        rs1_addr = 5'd8; rs2_addr = 5'd8; check_comb();
        chk("x8_dual_stall", {63'd0, stall}, 64'd1);
        rs1_rena = 1'b0; rs2_rena = 1'b0; check_comb();
        chk("x8_noren_stall", {63'd0, stall}, 64'd0);
        chk("x8_noren_rs1", rs1_data, 64'd0);
        chk("x8_noren_rs2", rs2_data, 64'd0); clock();
        idle(); wb(5'd8, 64'h88); check_comb(); clock();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 49) == 0);
            issue_valid   = 1'($urandom_range(0, 1));
            issue_rd_wena = ($urandom_range(0, 3) != 0);
            issue_rd_addr = rnd_addr();
            rs1_rena      = ($urandom_range(0, 3) != 0);
            rs2_rena      = ($urandom_range(0, 3) != 0);
            rs1_addr      = rnd_addr();
            rs2_addr      = ($urandom_range(0, 4) == 0) ? rs1_addr : rnd_addr();
            wb_valid      = ($urandom_range(0, 2) != 0);
            if (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rd_addr = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            else
                wb_rd_addr = rnd_addr();
            wb_rd_data    = {$urandom, $urandom};
            check_comb();
            clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide ports in this order: clk, rst, then the ports below; one clock domain; reset synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 rs1_addr / rs2_addr  input  5 each  decode source register indices.
REQ-005 rs1_rena / rs2_rena  input  1 each  source read enables.
REQ-006 rs1_data / rs2_data  output  64 each  operand values to the execute stage (REG_BUS width).
REQ-007 issue_valid  input  1  decode issuing an instruction this cycle.
REQ-008 issue_rd_wena / issue_rd_addr  input  1 / 5  issued instruction writes rd / its index.
REQ-009 wb_valid / wb_rd_addr / wb_rd_data  input  1 / 5 / 64  execute-result writeback (execute rd_data).
REQ-010 stall  output  1  hazard; decode SHALL hold its instruction and the issue SHALL NOT be accepted.
REQ-011 busy_vec  output  32  pending-write bit per register, bit 0 always 0.

Function
REQ-012 SHALL hold 31 64-bit registers x1..x31; x0 reads 0, writes to x0 ignored.
REQ-013 Write: on clk edge with wb_valid=1 and wb_rd_addr!=0, regs[wb_rd_addr] <= wb_rd_data; visible on the following cycle's reads.
REQ-014 Read: combinational; rsN_rena=0 or rsN_addr=0 -> rsN_data=0; else regs[rsN_addr], subject to REQ-026/027.
REQ-015 Scoreboard pending[31:1]: set on edge when issue_valid & issue_rd_wena & issue_rd_addr!=0 & stall=0.
REQ-016 pending[a] cleared on edge when wb_valid & wb_rd_addr==a & a!=0.
REQ-017 Same-edge set and clear of the same register: set wins (pending stays 1).
REQ-018 wb_valid to a non-pending register: write performed, pending unchanged, no error.
REQ-019 RAW hazard: rsN_rena & rsN_addr!=0 & pending[rsN_addr] & not bypass-resolved (REQ-026) -> stall=1.
REQ-020 WAW hazard: issue_valid & issue_rd_wena & issue_rd_addr!=0 & pending[issue_rd_addr] & not cleared by wb this cycle -> stall=1.
REQ-021 stall SHALL be 0 whenever issue_valid=0.
REQ-022 stall is combinational from current inputs and pending; no added latency.
REQ-023 busy_vec = {pending[31:1], 1'b0}, registered (reflects state after last edge).
REQ-024 Both read ports independent; rs1_addr==rs2_addr SHALL return identical data and identical hazard result.
REQ-025 At most one outstanding write per register by construction (REQ-020).

Reset
REQ-028 On clk edge with rst=1: all registers <= 0, pending <= 0; wb and issue in that cycle ignored.
REQ-029 Reset mid-operation discards all pending writebacks; first cycle after reset: busy_vec=0, stall=0, all reads 0.
REQ-030 Outputs during rst=1 follow REQ-014/019 from pre-reset state; values meaningless until deassert.

Configuration
REQ-026 With REGFILE_BYPASS_EN defined: wb_valid & wb_rd_addr==rsN_addr & rsN_addr!=0 -> rsN_data=wb_rd_data same cycle and that source raises no RAW stall.
REQ-027 Without REGFILE_BYPASS_EN: no forwarding; rsN_data=stored value, RAW stall remains 1 in the writeback cycle, released the cycle after.

Verification
REQ-031 Reset, then write x5=0x1234 via wb, read rs1=x5 next cycle -> rs1_data=0x1234; read x0 after wb to x0 with 0xFFFF -> 0.
REQ-032 Issue rd=x7, next cycle read rs2=x7 -> stall=1, busy_vec[7]=1; wb x7=0xAA -> bypass build: stall=0, rs2_data=0xAA same cycle; non-bypass build: stall=1 that cycle, 0 next, rs2_data=0xAA.
REQ-033 Same edge wb x9 and issue rd=x9 (x9 pending) -> stall=0, busy_vec[9]=1 after edge.
REQ-034 x3 pending, issue rd=x3 with no wb -> stall=1, pending unchanged; wb x3 then reissue -> accepted.
REQ-035 Issue rd=x4,x6 pending, assert rst one cycle -> busy_vec=0, stall=0, x4/x6 read 0.
REQ-036 rs1=rs2=x8 pending, rena both 1 -> stall=1; rs2_rena=0, rs1_rena=0 -> stall=0, both data 0.
